// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the unified memory port arbiter.
//   state_t       : arbiter sequencing states (IDLE, BUSY, DONE)
//   REQ_CPU/LDR   : requester indices (0 = CPU control path, 1 = loader/debug)
//   CNT_W         : latency counter width, covers MEM_LAT up to 15
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LDR = 1'b1;

   // One-hot grant/done vector for a requester index.
   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   // Counter value of the final BUSY cycle for a given access latency.
   function automatic logic [CNT_W-1:0] last_count(input int unsigned lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the requester handshake and the memory-side bus of the arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, data, mem_* out)
//   master : requester/memory view (the opposite directions)
// Parameters: ADDR_W, DATA_W.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [1:0]        req;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        gnt;
   logic [1:0]        done;
   logic [DATA_W-1:0] rdata;
   logic              cpu_stall;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt, done, rdata, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt, done, rdata, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// ---------------------------------------------------------------------------
// lat_counter
// Counts the cycles of one memory access and flags its final cycle.
//   clk, Reset : clock, asynchronous active-high reset
//   clear      : force count to zero (held while the arbiter is idle)
//   enable     : advance the count by one
//   tc_c       : combinational terminal count, high when count == MEM_LAT-1
// Parameter: MEM_LAT (1..15).
// ---------------------------------------------------------------------------
module lat_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic clk,
   input  logic Reset,
   input  logic clear,
   input  logic enable,
   output logic tc_c
);

   logic [CNT_W-1:0] cnt;

   // Access cycle counter.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc_c = (cnt == last_count(MEM_LAT));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single unified memory port of the multicycle CPU between the
// CPU control path (requester 0) and the loader/debug port (requester 1).
// Each access runs IDLE -> BUSY (MEM_LAT cycles) -> DONE (one-cycle done).
//   clk, Reset      : clock, asynchronous active-high reset
//   bus.req/we      : per-requester request and write enable
//   bus.addr*/wdata*: per-requester address and write data
//   bus.gnt/done    : one-hot owner and one-cycle completion pulse
//   bus.rdata       : read data, valid while done is high
//   bus.cpu_stall   : req[0] & ~done[0], combinational
//   bus.mem_*       : memory enable, write enable, address, write/read data
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..15).
// Build option: ARB_FIXED_PRI_EN gives requester 0 absolute priority on a
// tie; without it ties are resolved round-robin.
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              Reset,
   mem_port_arbiter_if.slave bus
);

   state_t            state;
   logic [1:0]        gnt_q;
   logic [1:0]        done_q;
   logic [DATA_W-1:0] rdata_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              owner_we;
   logic              winner_c;
   logic              tc_c;

`ifdef ARB_FIXED_PRI_EN
   // CPU wins any tie.
   assign winner_c = bus.req[REQ_CPU] ? REQ_CPU : REQ_LDR;
`else
   logic last_gnt;

   // Sole requester wins; on a tie the one not served last wins.
   always_comb begin
      winner_c = REQ_CPU;
      if (bus.req == 2'b11) begin
         winner_c = ~last_gnt;
      end else if (bus.req[REQ_LDR]) begin
         winner_c = REQ_LDR;
      end
   end

   // Reset to the loader so the CPU takes the first tie.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         last_gnt <= REQ_LDR;
      end else if ((state == IDLE) && (|bus.req)) begin
         last_gnt <= winner_c;
      end
   end
`endif

   lat_counter #(
      .MEM_LAT (MEM_LAT)
   ) u_lat_counter (
      .clk    (clk),
      .Reset  (Reset),
      .clear  (state == IDLE),
      .enable (state == BUSY),
      .tc_c   (tc_c)
   );

   // Access sequencer; every port-facing output is a register here.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         gnt_q       <= '0;
         done_q      <= '0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         owner_we    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  state       <= BUSY;
                  gnt_q       <= onehot2(winner_c);
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= bus.we[winner_c];
                  owner_we    <= bus.we[winner_c];
                  mem_addr_q  <= (winner_c == REQ_LDR) ? bus.addr1 : bus.addr0;
                  mem_wdata_q <= (winner_c == REQ_LDR) ? bus.wdata1 : bus.wdata0;
               end
            end
            BUSY: begin
               // mem_rdata is valid in the final BUSY cycle only.
               if (tc_c) begin
                  state    <= DONE;
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  done_q   <= gnt_q;
                  if (!owner_we) begin
                     rdata_q <= bus.mem_rdata;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               gnt_q  <= '0;
               done_q <= '0;
            end
            default: begin
               state    <= IDLE;
               gnt_q    <= '0;
               done_q   <= '0;
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_stall = bus.req[REQ_CPU] & ~done_q[REQ_CPU];

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle CPU between two requesters: requester 0 = CPU control path (fetch/load/store accesses selected by IorD), requester 1 = program loader/debug port.
- Arbitrates, sequences each access through a fixed-latency memory, returns read data with a one-cycle done pulse, and drives a stall to the CPU control unit while its access is pending.
- Sits between the control unit/datapath and the memory block.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles, legal range 1..15

Ports:
clk  in  1  clock; all state updates on posedge
Reset  in  1  asynchronous, active-high reset
req  in  2  access request per requester; held high until done
we  in  2  write enable per requester (0 = read)
addr0  in  ADDR_W  requester 0 address
addr1  in  ADDR_W  requester 1 address
wdata0  in  DATA_W  requester 0 write data
wdata1  in  DATA_W  requester 1 write data
gnt  out  2  one-hot owner of the memory port
done  out  2  one-cycle completion pulse per requester
rdata  out  DATA_W  read data; valid while done is high
cpu_stall  out  1  req[0] & ~done[0]
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid in the last BUSY cycle

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; gnt = 0, done = 0, rdata = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - last_gnt = 1, so requester 0 wins the first tie.
- States: IDLE, BUSY, DONE.
- IDLE:
  - gnt = 0, mem_en = 0.
  - On a posedge with any req high: pick a winner, latch its we, addr and wdata into owner registers, set last_gnt = winner, cnt = 0, go to BUSY.
- Winner selection: only one requester high wins. Both high: winner = the requester not in last_gnt (round-robin).
- BUSY:
  - gnt[owner] = 1, mem_en = 1, mem_we/mem_addr/mem_wdata driven from the latched registers.
  - cnt increments each cycle.
  - When cnt == MEM_LAT-1: capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to DONE.
- DONE:
  - gnt[owner] = 1, done[owner] = 1 for exactly one cycle, mem_en = 0.
  - Next state is IDLE.
- Latency: a request sampled in IDLE at edge k gives done high in cycle k+MEM_LAT+1. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Input changes: req/addr/we changes after the grant edge are ignored. A req dropped mid-BUSY does not abort the access; the write still happens and done still pulses.
- A req still high in IDLE after done is treated as a new request. Requesters must drop req in the cycle after done.
- cpu_stall is combinational from req[0] and done[0].
- Reset asserted mid-BUSY: the access is aborted, no done pulse, memory outputs drop the same instant.
- At most one bit of gnt and one bit of done are ever high.
- mem_we is never high while mem_en is low.

Optional Feature:
- Macro: ARB_FIXED_PRI_EN.
- Defined: requester 0 (CPU) always wins when both request; last_gnt is not used.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package:
  - state enum (IDLE, BUSY, DONE)
  - requester id constants (REQ_CPU = 0, REQ_LDR = 1)
  - count width derived from MEM_LAT (4 bits)
- Sub-module lat_counter:
  - clear, enable, terminal-count output at MEM_LAT-1
  - async active-high Reset

Test Plan:
- Reset pulse at t=1, then req=01, we=00, addr0=0x10, mem_rdata=0xDEADBEEF: gnt=01 next edge; mem_en high 2 cycles with mem_addr=0x10; done=01 one cycle with rdata=0xDEADBEEF; cpu_stall low in that same cycle.
- req=10, we=10, addr1=0x40, wdata1=0x1234: mem_we=1, mem_wdata=0x1234 for 2 cycles; done=10; rdata unchanged.
- req=11 held continuously from reset: grant order 0,1,0,1. With ARB_FIXED_PRI_EN: 0,0,0.
- Requester 0 drops req one cycle after grant during a write: write still issued for MEM_LAT cycles; done[0] still pulses once.
- Reset asserted in the second BUSY cycle: mem_en, gnt and done go 0 immediately; after release, a pending req=01 is re-granted from IDLE.
- MEM_LAT=1 with req=01 held: done=01 every 3rd cycle; mem_en high 1 cycle per access.
